// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Brief    : Instruction fetch front end. Issues one-word reads to an
//             instruction memory with fixed one-cycle read latency, buffers
//             the returned words with their byte PCs in a small prefetch
//             FIFO, and hands them to the consumer through a valid/ready
//             head. Supports redirects (flush + new PC) and a halt request.
//  Revision : 1.0 - initial release
// ============================================================================
//  Notes
//  - DEPTH must be a power of two in 2..16 so the FIFO pointers wrap
//    naturally.
//  - AW is expected to be in 2..29 so fetch_pc[AW+1:2] is a proper slice
//    with high PC bits left over.
//  - Flow control is credit based. A request is issued only when the
//    words already buffered, plus the one in flight, minus the one leaving
//    this cycle, leave room for the new word. For that reason a response
//    never needs to be dropped for lack of space.
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          AW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    output logic          inst_valid,
    output logic [31:0]   inst,
    output logic [31:0]   inst_pc,
    input  logic          inst_ready,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    input  logic          halt,
    output logic          halted
);

    // ------------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------------
    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [CW-1:0] count_q,    count_d;
    logic          inflight_q;
    logic [31:0]   inflight_pc_q;
    state_t        state_q;
    logic          halted_q;

    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_inst_q [DEPTH];

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic          w_head_valid;
    logic          w_pop;
    logic          w_push;
    logic [CW:0]   w_occupancy;
    logic          w_req;
    logic          w_unused;

    // Head of the FIFO is visible straight from the storage registers.
    assign w_head_valid = (count_q != '0);

    // A pop needs a valid head; an inst_ready with an empty FIFO is ignored.
    assign w_pop = w_head_valid && inst_ready;

    // The word returned for last cycle's request lands unless a redirect
    // kills it. The in-flight flag is cleared by reset, so a response that
    // arrives just after reset release is never buffered.
    assign w_push = inflight_q && !redirect_valid;

    // Slots that will be committed after this cycle without a new request.
    // A pop implies count_q >= 1, so the subtraction cannot underflow.
    assign w_occupancy = {1'b0, count_q}
                       + {{CW{1'b0}}, inflight_q}
                       - {{CW{1'b0}}, w_pop};

    // Request gating: out of reset, running, not halting, not redirecting,
    // and a free slot for the returning word.
    assign w_req = rst
                && (state_q == ST_RUN)
                && !halt
                && !redirect_valid
                && (w_occupancy < DEPTH_W);

    // Redirect offset bits and the PC bits outside the word address are
    // intentionally not consumed.
    assign w_unused = ^{redirect_pc[1:0], fetch_pc_q[1:0], fetch_pc_q[31:AW+2]};

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign imem_req   = w_req;
    assign imem_addr  = fetch_pc_q[AW+1:2];
    assign inst_valid = w_head_valid;
    assign inst       = w_head_valid ? fifo_inst_q[rd_ptr_q] : 32'h0;
    assign inst_pc    = w_head_valid ? fifo_pc_q[rd_ptr_q]   : 32'h0;
    assign halted     = halted_q;

    // Next-state for the fetch PC and the FIFO bookkeeping; a redirect
    // overrides everything, and any same-cycle pop is simply subsumed by
    // the flush.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (w_req) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(w_push) - CW'(w_pop);
        end
    end

    // Fetch PC, FIFO pointers/count and the in-flight tracker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= w_req;
            if (w_req) begin
                inflight_pc_q <= fetch_pc_q;
            end
        end
    end

    // FIFO storage; contents are only meaningful below count_q, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_pc_q[wr_ptr_q]   <= inflight_pc_q;
            fifo_inst_q[wr_ptr_q] <= imem_rdata;
        end
    end

    // Run/halt state machine with a registered halted flag. Halt blocks
    // requests in the same cycle, so the in-flight slot is always empty
    // after a halt cycle and the transition can be taken immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (halt && !w_req) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (!halt) begin
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Brief    : Self-checking bench for fetch_unit. A queue-based model tracks
//             every outstanding fetch (issued, not yet consumed) with the
//             cycle it was issued; the model predicts request gating,
//             head visibility, delivered PC/word and the halted flag.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam int          AW       = 16;

    logic          clk;
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          inst_valid;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic          inst_ready;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          halt;
    logic          halted;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .AW       (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bookkeeping
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc   = 0;
    int           n_req = 0;
    int           n_pop = 0;
    logic [31:0]  popped [$];

    // Reference model: outstanding fetches in program order
    logic [31:0]  q_pc  [$];
    int           q_cyc [$];
    logic [31:0]  m_fetch;
    logic         m_halted;

    // Memory responder state
    logic          prev_req;
    logic [AW-1:0] prev_addr;

    function automatic logic [31:0] word_at(input logic [AW-1:0] a);
        return 32'h1000_0000 + {16'h0, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, let it settle,
    // compare against the model, then advance the model.
    task automatic cycle(input logic rdy, input logic redir,
                         input logic [31:0] rpc, input logic hlt);
        logic        exp_valid;
        logic        exp_req;
        logic        pop;
        logic [31:0] hp;
        @(negedge clk);
        rst            = 1'b1;
        inst_ready     = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        halt           = hlt;
        imem_rdata     = prev_req ? word_at(prev_addr) : $urandom();
        #1;
        exp_valid = (q_pc.size() > 0) && (q_cyc[0] + 2 <= cyc);
        pop       = exp_valid && rdy;
        exp_req   = !m_halted && !hlt && !redir
                  && ((q_pc.size() - (pop ? 1 : 0)) < DEPTH);

        chk("inst_valid", {31'b0, inst_valid}, {31'b0, exp_valid});
        chk("imem_req",   {31'b0, imem_req},   {31'b0, exp_req});
        chk("halted",     {31'b0, halted},     {31'b0, m_halted});
        if (exp_valid) begin
            hp = q_pc[0];
            chk("inst_pc", inst_pc, hp);
            chk("inst",    inst,    word_at(hp[AW+1:2]));
        end
        if (exp_req) begin
            chk("imem_addr", {16'h0, imem_addr}, {16'h0, m_fetch[AW+1:2]});
        end

        if (imem_req) n_req++;
        if (inst_valid && rdy) begin
            n_pop++;
            popped.push_back(inst_pc);
        end

        if (pop) begin
            void'(q_pc.pop_front());
            void'(q_cyc.pop_front());
        end
        if (redir) begin
            q_pc.delete();
            q_cyc.delete();
            m_fetch = {rpc[31:2], 2'b00};
        end else if (exp_req) begin
            q_pc.push_back(m_fetch);
            q_cyc.push_back(cyc);
            m_fetch = m_fetch + 32'd4;
        end
        m_halted  = hlt;
        prev_req  = imem_req;
        prev_addr = imem_addr;
        cyc++;
    endtask

    // Asynchronous reset pulse placed between the falling and rising edge;
    // outputs must show reset values before any clock edge.
    task automatic do_reset(input int ncyc);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_imem_req",   {31'b0, imem_req},   32'h0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_inst",       inst,                32'h0);
        chk("rst_inst_pc",    inst_pc,             32'h0);
        chk("rst_halted",     {31'b0, halted},     32'h0);
        chk("rst_imem_addr",  {16'h0, imem_addr},  {16'h0, RESET_PC[AW+1:2]});
        q_pc.delete();
        q_cyc.delete();
        m_fetch  = RESET_PC;
        m_halted = 1'b0;
        prev_req = 1'b0;
        repeat (ncyc) @(posedge clk);
    endtask

    initial begin
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        hlt;
        int          hcnt;

        rst            = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        imem_rdata     = 32'h0;
        m_fetch        = RESET_PC;
        m_halted       = 1'b0;
        prev_req       = 1'b0;
        prev_addr      = '0;

        // Power-on reset
        do_reset(3);

        // Streaming from reset: first req at cycle 0, heads from cycle 2 on
        n_pop = 0;
        repeat (12) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("s1_pop_count", n_pop, 32'd10);

        // Stall: exactly DEPTH requests, then drain in order
        cycle(1'b1, 1'b1, 32'h0, 1'b0);
        n_req = 0;
        repeat (20) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("s2_req_count", n_req, 32'd4);
        chk("s2_req_idle", {31'b0, imem_req}, 32'h0);
        popped.delete();
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("s2_drain_count", popped.size(), 32'd6);
        for (int i = 0; i < 6 && i < popped.size(); i++)
            chk("s2_drain_pc", popped[i], 32'(4 * i));

        // Redirect with 3 buffered and 1 in flight
        cycle(1'b0, 1'b1, 32'h0, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("s3_pre_valid", {31'b0, inst_valid}, 32'h1);
        popped.delete();
        cycle(1'b0, 1'b1, 32'h0000_0103, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("s3_flushed", {31'b0, inst_valid}, 32'h0);
        chk("s3_addr", {16'h0, imem_addr}, 32'h40);
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("s3_count", popped.size(), 32'd3);
        if (popped.size() > 0) chk("s3_first_pc", popped[0], 32'h100);

        // Redirect and pop in the same cycle
        popped.delete();
        cycle(1'b1, 1'b1, 32'h0000_0300, 1'b0);
        repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("s4_count", popped.size(), 32'd4);
        if (popped.size() > 1) begin
            chk("s4_popped_old", popped[0], 32'h10C);
            chk("s4_first_new",  popped[1], 32'h300);
        end

        // Halt, redirect while halted, release
        n_req = 0;
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("s5_no_req", n_req, 32'd0);
        chk("s5_halted", {31'b0, halted}, 32'h1);
        cycle(1'b1, 1'b1, 32'h0000_0200, 1'b1);
        popped.delete();
        repeat (5) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("s5_count", popped.size(), 32'd2);
        if (popped.size() > 0) chk("s5_first_pc", popped[0], 32'h200);

        // Reset pulse with buffered entries and a request in flight
        cycle(1'b0, 1'b1, 32'h0000_0800, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        do_reset(2);
        popped.delete();
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("s6_restart_addr", {16'h0, imem_addr}, {16'h0, RESET_PC[AW+1:2]});
        repeat (7) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        if (popped.size() > 0) chk("s6_first_pc", popped[0], RESET_PC);
        else chk("s6_first_pc_present", popped.size(), 32'd1);

        // Randomized traffic
        hcnt = 0;
        for (int i = 0; i < 400; i++) begin
            rdy   = ($urandom_range(0, 9) < 7);
            redir = ($urandom_range(0, 99) < 5);
            rpc   = $urandom_range(0, 32'h3FFFF);
            if (hcnt > 0) begin
                hlt  = 1'b1;
                hcnt = hcnt - 1;
            end else begin
                hlt = 1'b0;
                if ($urandom_range(0, 99) < 3) hcnt = $urandom_range(1, 8);
            end
            cycle(rdy, redir, rpc, hlt);
            if (i == 200) do_reset(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
